// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_pkg;

  localparam int unsigned SERIAL_WIDTH = 32;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/serial_if.sv
// Frame request and serial output bundle between a host and the serial transmitter.
interface serial_if
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
);

  logic             load_data;
  logic [WIDTH-1:0] data_in;
  logic             data_enable;
  logic             sdo;

  modport master (
    output load_data,
    output data_in,
    input  data_enable,
    input  sdo
  );

  modport slave (
    input  load_data,
    input  data_in,
    output data_enable,
    output sdo
  );

endinterface

// File: rtl/serial.sv
// MSB-first parallel-to-serial transmitter with a registered chip-select window of WIDTH cycles.
// Back-to-back frames reload on the last bit with no gap cycle.
module serial
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH
) (
  input logic      sclk,
  input logic      rst_n,
  serial_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             sdo_q, sdo_d;
  logic             start;

  // A new frame may only begin from idle or on the final bit of the current frame.
  assign start = bus.load_data && ((state_q == StIdle) || (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    sdo_d   = sdo_q;

    unique case (state_q)
      StIdle: begin
        if (!start) begin
          en_d  = 1'b0;
          sdo_d = 1'b0;
        end
      end
      StShift: begin
        if (cnt_q != '0) begin
          shift_d = shift_q << 1;
          sdo_d   = shift_q[WIDTH-2];
          cnt_d   = cnt_q - 1'b1;
        end else if (!start) begin
          en_d    = 1'b0;
          sdo_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      shift_d = bus.data_in;
      sdo_d   = bus.data_in[WIDTH-1];
      en_d    = 1'b1;
      cnt_d   = CntW'(WIDTH - 1);
      state_d = StShift;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      sdo_q   <= sdo_d;
    end
  end

  assign bus.data_enable = en_q;
  assign bus.sdo         = sdo_q;

endmodule

// File: tb/tb_serial.sv
// Directed bench for serial: 32-bit and 8-bit instances driven from one linear sequence.
module tb_serial;

  logic sclk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_if #(.WIDTH(32)) if32 ();
  serial_if #(.WIDTH(8))  if8 ();

  serial #(.WIDTH(32)) u_dut32 (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (if32)
  );

  serial #(.WIDTH(8)) u_dut8 (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one full frame starting from the cycle showing bit 0, ending one tick past the last bit.
  task automatic check_frame(input string tag, input logic [63:0] word, input int w,
                             input bit sel8);
    for (int k = 0; k < w; k++) begin
      chk({tag, "_en"}, 64'(sel8 ? if8.data_enable : if32.data_enable), 64'(1));
      chk({tag, "_sdo"}, 64'(sel8 ? if8.sdo : if32.sdo), 64'(word[w-1-k]));
      tick();
    end
  endtask

  task automatic check_idle32(input string tag);
    chk({tag, "_en"}, 64'(if32.data_enable), 64'(0));
    chk({tag, "_sdo"}, 64'(if32.sdo), 64'(0));
  endtask

  initial begin
    logic [63:0] word;
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    if32.load_data = 1'b0;
    if32.data_in   = '0;
    if8.load_data  = 1'b0;
    if8.data_in    = '0;

    #12;
    check_idle32("reset32");
    chk("reset8_en", 64'(if8.data_enable), 64'(0));
    chk("reset8_sdo", 64'(if8.sdo), 64'(0));

    // Basic frame; first edge after reset release starts it.
    rst_n          = 1'b1;
    word           = 64'hF0F0_0F0F;
    if32.data_in   = 32'hF0F0_0F0F;
    if32.load_data = 1'b1;
    tick();
    if32.load_data = 1'b0;
    check_frame("f0f0", word, 32, 1'b0);
    check_idle32("f0f0_tail");
    tick();
    check_idle32("f0f0_tail2");

    // Continuous frames with load held high.
    word           = 64'hAAAA_AAAA;
    if32.data_in   = 32'hAAAA_AAAA;
    if32.load_data = 1'b1;
    tick();
    for (int k = 0; k < 64; k++) begin
      chk("b2b_en", 64'(if32.data_enable), 64'(1));
      chk("b2b_sdo", 64'(if32.sdo), 64'(word[31-(k%32)]));
      if (k == 31) begin
        word         = 64'h5555_5555;
        if32.data_in = 32'h5555_5555;
      end
      if (k == 63) if32.load_data = 1'b0;
      tick();
    end
    check_idle32("b2b_tail");

    // Mid-frame load pulse must be ignored.
    tick();
    word           = 64'hFFFF_FFFF;
    if32.data_in   = 32'hFFFF_FFFF;
    if32.load_data = 1'b1;
    tick();
    if32.load_data = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("ign_en", 64'(if32.data_enable), 64'(1));
      chk("ign_sdo", 64'(if32.sdo), 64'(word[31-k]));
      if32.load_data = (k == 10);
      tick();
    end
    check_idle32("ign_tail");
    tick();
    check_idle32("ign_tail2");

    // Asynchronous reset mid-frame.
    word           = 64'hA5A5_A5A5;
    if32.data_in   = 32'hA5A5_A5A5;
    if32.load_data = 1'b1;
    tick();
    if32.load_data = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_bit5_sdo", 64'(if32.sdo), 64'(word[26]));
    chk("rst_bit5_en", 64'(if32.data_enable), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_idle32("rst_async");
    tick();
    check_idle32("rst_held");
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle32("rst_after");
    end

    // Input changes after the load edge do not disturb the frame.
    word           = 64'h8000_0001;
    if32.data_in   = 32'h8000_0001;
    if32.load_data = 1'b1;
    tick();
    if32.load_data = 1'b0;
    if32.data_in   = 32'h0;
    check_frame("hold", word, 32, 1'b0);
    check_idle32("hold_tail");

    // Narrow instance.
    word          = 64'hC3;
    if8.data_in   = 8'hC3;
    if8.load_data = 1'b1;
    tick();
    if8.load_data = 1'b0;
    check_frame("w8", word, 8, 1'b1);
    chk("w8_tail_en", 64'(if8.data_enable), 64'(0));
    chk("w8_tail_sdo", 64'(if8.sdo), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial.md
SERIAL -- requirements
Module: serial

Interface
REQ-001 Parameter WIDTH, default 32, frame length in bits (legal range 2..64).
REQ-002 sclk  input  1  serial clock; the only clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 load_data  input  1  frame start request, sampled high on a rising sclk edge.
REQ-005 data_in  input  WIDTH  parallel word to transmit, sampled with load_data.
REQ-006 data_enable  output  1  high (active-high chip select) for exactly WIDTH cycles per frame.
REQ-007 sdo  output  1  serial data out, MSB first; low whenever data_enable is low.

Function
REQ-008 FSM states: IDLE, SHIFT; encoding is implementer's choice.
REQ-009 IDLE with load_data=1 at edge E: at E, shift_reg<=data_in, sdo<=data_in[WIDTH-1], data_enable<=1, bit_cnt<=WIDTH-1, go SHIFT.
REQ-010 IDLE with load_data=0: hold data_enable=0, sdo=0.
REQ-011 SHIFT with bit_cnt>0: at each edge, sdo<=next lower bit (shift left), bit_cnt<=bit_cnt-1.
REQ-012 Bit k of the frame (k=0 for MSB) drives sdo during the cycle after edge E+k; a receiver samples on falling sclk.
REQ-013 SHIFT with bit_cnt=0 (last bit): with load_data=0, data_enable<=0, sdo<=0, go IDLE.
REQ-014 SHIFT with bit_cnt=0 and load_data=1: back-to-back frame; reload per REQ-009 with no gap cycle, data_enable stays 1.
REQ-015 load_data high while SHIFT with bit_cnt>0 is ignored; the current frame is never truncated or restarted.
REQ-016 load_data held high continuously yields continuous frames, each re-sampling data_in at its start edge.
REQ-017 data_in changes after the load edge do not affect the frame in progress.
REQ-018 Outputs are registered; no combinational path from inputs to outputs.
REQ-019 bit_cnt width is $clog2(WIDTH); no wrap-around beyond the defined decrement to 0.

Reset
REQ-020 rst_n low: immediately (asynchronously) state=IDLE, data_enable=0, sdo=0, shift_reg=0, bit_cnt=0.
REQ-021 Reset asserted mid-frame aborts the frame; no bits are emitted after rst_n rises until a new load_data.
REQ-022 First edge after rst_n deassertion behaves as IDLE (load_data=1 there starts a frame).

Structure
REQ-023 Shared package serial_pkg holds the state enum typedef and the default-width constant SERIAL_WIDTH=32.
REQ-024 Single flat module; no sub-module needed (optional bit counter inline).

Verification
REQ-025 Reset, then load_data=1 for one cycle with data_in=32'hF0F00F0F -> data_enable high 32 cycles; sdo sequence 1111 0000 1111 0000 0000 1111 0000 1111; then data_enable=0, sdo=0.
REQ-026 load_data held high, data_in=32'hAAAAAAAA then 32'h55555555 at second frame start -> 64 contiguous enable cycles, sdo alternates 1010..., then 0101..., no gap.
REQ-027 Pulse load_data at bit 10 of a frame of 32'hFFFFFFFF -> ignored; exactly 32 ones, then idle.
REQ-028 Assert rst_n=0 at bit 5 of a frame between clock edges -> data_enable and sdo drop to 0 immediately; stay idle after release.
REQ-029 Change data_in on the cycle after load (32'h80000001 -> 32'h0) -> sdo still emits 1, thirty 0s, 1.
REQ-030 WIDTH=8, data_in=8'hC3 -> 8 enable cycles, sdo 1100 0011.
